branch_predictor_btb: RTL and testbench

- Parametrised branch target buffer with per-entry saturating direction counters. It replaces the current flush-on-every-taken-branch policy with fetch-stage prediction.
- Sits beside program_counter and instruction_memory in IF. It supplies the predicted next PC and is trained by the resolving stage (ID branching unit or EX).
- Also keeps saturating performance counters for resolved branches and mispredicts.

---
 rtl/bp_pkg.sv | 50 +++++
 rtl/branch_predictor_btb_sat_counter.sv | 33 +++
 rtl/branch_predictor_btb.sv | 93 +++++++++
 tb/tb_branch_predictor_btb.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer: counter encodings,
// table entry layout and PC field extraction.
package bp_pkg;

    localparam int unsigned BP_MAX_W     = 64;
    localparam int unsigned BP_MAX_CNT_W = 8;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Fields are sized for the widest supported configuration; bits above the
    // configured widths are always written as zero.
    typedef struct packed {
        logic                      valid;
        logic [BP_MAX_W-1:0]       tag;
        logic [BP_MAX_W-1:0]       target;
        logic [BP_MAX_CNT_W-1:0]   cnt;
    } btb_entry_t;

    function automatic logic [BP_MAX_CNT_W-1:0] cnt_wt(input int unsigned cnt_w);
        return BP_MAX_CNT_W'(1) << (cnt_w - 1);
    endfunction

    function automatic logic [BP_MAX_CNT_W-1:0] cnt_wnt(input int unsigned cnt_w);
        return (BP_MAX_CNT_W'(1) << (cnt_w - 1)) - BP_MAX_CNT_W'(1);
    endfunction

    function automatic logic [BP_MAX_CNT_W-1:0] cnt_next(input logic [BP_MAX_CNT_W-1:0] cnt,
                                                         input logic taken,
                                                         input int unsigned cnt_w);
        logic [BP_MAX_CNT_W-1:0] max_val;
        max_val = (BP_MAX_CNT_W'(1) << cnt_w) - BP_MAX_CNT_W'(1);
        if (taken) return (cnt == max_val) ? cnt : cnt + BP_MAX_CNT_W'(1);
        return (cnt == '0) ? cnt : cnt - BP_MAX_CNT_W'(1);
    endfunction

    function automatic logic [BP_MAX_W-1:0] pc_idx(input logic [BP_MAX_W-1:0] pc,
                                                   input int unsigned idx_w);
        return (pc >> 2) & ((BP_MAX_W'(1) << idx_w) - BP_MAX_W'(1));
    endfunction

    function automatic logic [BP_MAX_W-1:0] pc_tag(input logic [BP_MAX_W-1:0] pc,
                                                   input int unsigned idx_w,
                                                   input int unsigned tag_w);
        return (pc >> (idx_w + 2)) & ((BP_MAX_W'(1) << tag_w) - BP_MAX_W'(1));
    endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Up/down counter that saturates at both ends, with synchronous clear.
module sat_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clear,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (inc && !dec && (value_q != '1)) begin
            value_d = value_q + WIDTH'(1);
        end else if (dec && !inc && (value_q != '0)) begin
            value_d = value_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters and saturating perf counters for resolved / mispredicted branches.
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 12,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_next_pc,
    input  logic              update_valid,
    input  logic [XLEN-1:0]   update_pc,
    input  logic              update_taken,
    input  logic [XLEN-1:0]   update_target,
    input  logic              update_mispredict,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispred
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    btb_entry_t table_q [ENTRIES];

    logic [IDX_W-1:0]    lk_idx, up_idx;
    logic [BP_MAX_W-1:0] lk_tag, up_tag;
    logic                up_hit;

    assign lk_idx = IDX_W'(pc_idx(BP_MAX_W'(lookup_pc), IDX_W));
    assign lk_tag = pc_tag(BP_MAX_W'(lookup_pc), IDX_W, TAG_W);
    assign up_idx = IDX_W'(pc_idx(BP_MAX_W'(update_pc), IDX_W));
    assign up_tag = pc_tag(BP_MAX_W'(update_pc), IDX_W, TAG_W);

    // Lookup reads registered state only, so a same-cycle update is not seen.
    always_comb begin
        pred_hit     = table_q[lk_idx].valid && (table_q[lk_idx].tag == lk_tag);
        pred_taken   = pred_hit && table_q[lk_idx].cnt[CNT_W-1];
        pred_next_pc = pred_taken ? table_q[lk_idx].target[XLEN-1:0]
                                  : lookup_pc + XLEN'(4);
    end

    assign up_hit = table_q[up_idx].valid && (table_q[up_idx].tag == up_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i].valid  <= 1'b0;
                table_q[i].tag    <= '0;
                table_q[i].target <= '0;
                table_q[i].cnt    <= cnt_wnt(CNT_W);
            end
        end else if (update_valid) begin
            if (up_hit) begin
                table_q[up_idx].cnt <= cnt_next(table_q[up_idx].cnt, update_taken, CNT_W);
                if (update_taken) table_q[up_idx].target <= BP_MAX_W'(update_target);
            end else if (update_taken) begin
                table_q[up_idx].valid  <= 1'b1;
                table_q[up_idx].tag    <= up_tag;
                table_q[up_idx].target <= BP_MAX_W'(update_target);
                table_q[up_idx].cnt    <= cnt_wt(CNT_W);
            end
        end
    end

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_perf_branches (
        .clk   (clk),
        .reset (reset),
        .inc   (update_valid),
        .dec   (1'b0),
        .clear (1'b0),
        .value (perf_branches)
    );

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_perf_mispred (
        .clk   (clk),
        .reset (reset),
        .inc   (update_valid && update_mispredict),
        .dec   (1'b0),
        .clear (1'b0),
        .value (perf_mispred)
    );

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed self-checking bench for branch_predictor_btb (16 entries, 4-bit perf counters).
module tb_branch_predictor_btb;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned PERF_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [XLEN-1:0]   lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_next_pc;
    logic              update_valid;
    logic [XLEN-1:0]   update_pc;
    logic              update_taken;
    logic [XLEN-1:0]   update_target;
    logic              update_mispredict;
    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_mispred;

    int n_checks = 0;
    int n_pass   = 0;

    branch_predictor_btb #(
        .XLEN    (XLEN),
        .ENTRIES (16),
        .TAG_W   (12),
        .CNT_W   (2),
        .PERF_W  (PERF_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .lookup_pc         (lookup_pc),
        .pred_hit          (pred_hit),
        .pred_taken        (pred_taken),
        .pred_next_pc      (pred_next_pc),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .perf_branches     (perf_branches),
        .perf_mispred      (perf_mispred)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Drive one update for a single cycle; returns just after the capturing edge.
    task automatic upd(input logic [63:0] pc, input logic taken, input logic [63:0] tgt,
                       input logic mp);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_taken      = taken;
        update_target     = tgt;
        update_mispredict = mp;
        @(posedge clk);
        #1;
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    task automatic look(input logic [63:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    initial begin
        reset = 1'b1; lookup_pc = 64'h100; update_valid = 1'b0; update_pc = '0;
        update_taken = 1'b0; update_target = '0; update_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        look(64'h100);
        check("rst_hit", 64'(pred_hit), 64'd0);
        check("rst_taken", 64'(pred_taken), 64'd0);
        check("rst_next", pred_next_pc, 64'h104);
        check("rst_perf_br", 64'(perf_branches), 64'd0);
        check("rst_perf_mp", 64'(perf_mispred), 64'd0);

        // Allocate as weakly taken
        upd(64'h100, 1'b1, 64'h80, 1'b1);
        look(64'h100);
        check("alloc_hit", 64'(pred_hit), 64'd1);
        check("alloc_taken", 64'(pred_taken), 64'd1);
        check("alloc_next", pred_next_pc, 64'h80);

        // WT -> ST -> ST, then not-taken must give WT (still taken) with target kept
        upd(64'h100, 1'b1, 64'h80, 1'b0);
        upd(64'h100, 1'b1, 64'h80, 1'b0);
        upd(64'h100, 1'b0, 64'h999, 1'b1);
        look(64'h100);
        check("st_sat_taken", 64'(pred_taken), 64'd1);
        check("nt_keeps_target", pred_next_pc, 64'h80);

        // WT -> WNT
        upd(64'h100, 1'b0, 64'h0, 1'b0);
        check("wnt_hit", 64'(pred_hit), 64'd1);
        check("wnt_taken", 64'(pred_taken), 64'd0);
        check("wnt_next", pred_next_pc, 64'h104);

        // WNT -> SNT -> SNT, taken -> WNT (not taken), taken -> WT
        upd(64'h100, 1'b0, 64'h0, 1'b0);
        upd(64'h100, 1'b0, 64'h0, 1'b0);
        upd(64'h100, 1'b1, 64'h80, 1'b1);
        check("snt_sat_taken", 64'(pred_taken), 64'd0);
        check("snt_sat_hit", 64'(pred_hit), 64'd1);
        upd(64'h100, 1'b1, 64'h80, 1'b0);
        check("wt_again_next", pred_next_pc, 64'h80);
        check("perf_br_mid", 64'(perf_branches), 64'd9);
        check("perf_mp_mid", 64'(perf_mispred), 64'd3);

        // Alias: 0x140 shares idx 0 with 0x100 but has tag 5
        look(64'h140);
        check("alias_miss", 64'(pred_hit), 64'd0);
        upd(64'h140, 1'b1, 64'h200, 1'b0);
        look(64'h140);
        check("alias_hit", 64'(pred_hit), 64'd1);
        check("alias_next", pred_next_pc, 64'h200);
        look(64'h100);
        check("alias_evicted", 64'(pred_hit), 64'd0);
        upd(64'h100, 1'b0, 64'h0, 1'b0);
        check("miss_nt_nochange", 64'(pred_hit), 64'd0);
        look(64'h140);
        check("alias_kept_next", pred_next_pc, 64'h200);

        // Same-cycle lookup and allocation: no bypass
        lookup_pc         = 64'h100;
        update_valid      = 1'b1;
        update_pc         = 64'h100;
        update_taken      = 1'b1;
        update_target     = 64'h80;
        #1;
        check("nobypass_hit", 64'(pred_hit), 64'd0);
        @(posedge clk);
        #1 update_valid = 1'b0;
        check("after_alloc_hit", 64'(pred_hit), 64'd1);
        check("after_alloc_next", pred_next_pc, 64'h80);

        // Reset overrides a same-cycle update
        @(negedge clk);
        reset             = 1'b1;
        update_valid      = 1'b1;
        update_pc         = 64'h300;
        update_taken      = 1'b1;
        update_target     = 64'h40;
        update_mispredict = 1'b1;
        @(posedge clk);
        #1;
        reset             = 1'b0;
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
        look(64'h300);
        check("rstprio_hit", 64'(pred_hit), 64'd0);
        check("rstprio_br", 64'(perf_branches), 64'd0);
        check("rstprio_mp", 64'(perf_mispred), 64'd0);
        look(64'h100);
        check("rst_clears_table", 64'(pred_hit), 64'd0);

        // Mispredict flag without update_valid is ignored
        for (int i = 0; i < 3; i++) upd(64'h500, 1'b0, 64'h0, 1'b0);
        update_mispredict = 1'b1;
        @(posedge clk);
        #1 update_mispredict = 1'b0;
        check("perf_br_3", 64'(perf_branches), 64'd3);
        check("mp_needs_valid", 64'(perf_mispred), 64'd0);

        // Saturation of perf counters
        for (int i = 0; i < 20; i++) upd(64'h500, 1'b0, 64'h0, 1'b1);
        check("perf_br_sat", 64'(perf_branches), 64'd15);
        check("perf_mp_sat", 64'(perf_mispred), 64'd15);

        // Wrap-around of fall-through PC
        look(64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_hit", 64'(pred_hit), 64'd0);
        check("wrap_next", pred_next_pc, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
